// File: rtl/pe_operand_feeder.sv
// pe_operand_feeder: streams buffered ifm/weight pairs into one PE,
// drains the PE pipeline and captures its partial sum.
module pe_operand_feeder #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 18,
    parameter int AW     = 5,
    parameter int PSUM_W = 32,
    parameter int PE_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WIDTH-1:0]  wr_ifm,
    input  logic [WIDTH-1:0]  wr_w,
    input  logic              start,
    input  logic [AW-1:0]     cfg_len,
    output logic              busy,
    output logic              pe_clear,
    output logic [WIDTH-1:0]  ifm_out,
    output logic [WIDTH-1:0]  w_out,
    output logic              pe_done,
    input  logic [PSUM_W-1:0] psum_in,
    output logic [PSUM_W-1:0] result,
    output logic              result_valid
);

    localparam int DW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
    localparam logic [AW-1:0] DEPTH_C = AW'(DEPTH);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PE_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } state_e;

    state_e state_q, state_d;

    logic [AW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     len_q, len_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic              busy_q, busy_d;
    logic              clr_q, clr_d;
    logic [WIDTH-1:0]  ifm_q, ifm_d;
    logic [WIDTH-1:0]  w_q, w_d;
    logic              done_q, done_d;
    logic [PSUM_W-1:0] res_q, res_d;
    logic              rv_q, rv_d;
    logic              pend_q, pend_d;
    logic [AW-1:0]     pend_addr_q;
    logic [WIDTH-1:0]  pend_ifm_q;
    logic [WIDTH-1:0]  pend_w_q;

    logic [WIDTH-1:0] ifm_buf [DEPTH];
    logic [WIDTH-1:0] w_buf   [DEPTH];

    logic             idle_w;
    logic             take_wr;
    logic             buf_we;
    logic [AW-1:0]    buf_addr;
    logic [WIDTH-1:0] buf_ifm;
    logic [WIDTH-1:0] buf_w;

    // busy_q stays high through the pe_done cycle, so idle means both low
    assign idle_w  = (state_q == IDLE) && !busy_q;
    assign take_wr = idle_w && wr_en && (wr_addr < DEPTH_C);

    // A write arriving with start is parked until the run ends,
    // so the run sees the buffers as they were before it.
    always_comb begin
        buf_we   = 1'b0;
        buf_addr = wr_addr;
        buf_ifm  = wr_ifm;
        buf_w    = wr_w;
        pend_d   = pend_q;
        if (pend_q && (state_q == DONE)) begin
            buf_we   = 1'b1;
            buf_addr = pend_addr_q;
            buf_ifm  = pend_ifm_q;
            buf_w    = pend_w_q;
            pend_d   = 1'b0;
        end else if (take_wr && !start) begin
            buf_we = 1'b1;
        end
        if (take_wr && start) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            ifm_buf[buf_addr] <= buf_ifm;
            w_buf[buf_addr]   <= buf_w;
        end
        if (take_wr && start) begin
            pend_addr_q <= wr_addr;
            pend_ifm_q  <= wr_ifm;
            pend_w_q    <= wr_w;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        drain_d = drain_q;
        clr_d   = 1'b0;
        ifm_d   = '0;
        w_d     = '0;
        done_d  = 1'b0;
        rv_d    = 1'b0;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (idle_w && start) begin
                    len_d   = (cfg_len > DEPTH_C) ? DEPTH_C : cfg_len;
                    cnt_d   = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                clr_d   = 1'b1;
                drain_d = '0;
                state_d = (len_q != '0) ? STREAM : DRAIN;
            end
            STREAM: begin
                ifm_d = ifm_buf[cnt_q];
                w_d   = w_buf[cnt_q];
                if (cnt_q == len_q - AW'(1)) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (done_q) begin
            rv_d  = 1'b1;
            res_d = psum_in;
        end
        busy_d = (state_d != IDLE) || (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            clr_q   <= 1'b0;
            ifm_q   <= '0;
            w_q     <= '0;
            done_q  <= 1'b0;
            res_q   <= '0;
            rv_q    <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            clr_q   <= clr_d;
            ifm_q   <= ifm_d;
            w_q     <= w_d;
            done_q  <= done_d;
            res_q   <= res_d;
            rv_q    <= rv_d;
            pend_q  <= pend_d;
        end
    end

    assign busy         = busy_q;
    assign pe_clear     = clr_q;
    assign ifm_out      = ifm_q;
    assign w_out        = w_q;
    assign pe_done      = done_q;
    assign result       = res_q;
    assign result_valid = rv_q;

endmodule
